// File: rtl/uart_rx_if.sv
// uart_rx_if: byte-wide valid/ready output bundle of the UART receiver.
//   uart_rx_data      received byte, stable while uart_rx_valid=1
//   uart_rx_valid     byte available
//   uart_rx_ready     consumer accepts the byte
//   uart_rx_frame_err one-cycle pulse, stop bit sampled low
//   uart_rx_overrun   one-cycle pulse, byte dropped because the previous one was still pending
// modport master: receiver side; modport slave: consumer side.
interface uart_rx_if;
  logic [7:0] uart_rx_data;
  logic       uart_rx_valid;
  logic       uart_rx_ready;
  logic       uart_rx_frame_err;
  logic       uart_rx_overrun;

  modport master (
    output uart_rx_data,
    output uart_rx_valid,
    input  uart_rx_ready,
    output uart_rx_frame_err,
    output uart_rx_overrun
  );

  modport slave (
    input  uart_rx_data,
    input  uart_rx_valid,
    output uart_rx_ready,
    input  uart_rx_frame_err,
    input  uart_rx_overrun
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. One bit period is uart_divider+1 uart_clk cycles.
//
// Ports:
//   uart_clk      system clock
//   uart_rst_n    asynchronous active-low reset
//   uart_ser_rx   serial line, idle high, asynchronous to uart_clk
//   uart_divider  bit period minus one (legal 3..65535), latched at start detection
//   rx_if         uart_rx_if.master: data/valid/ready handshake plus error pulses
//
// Parameter SYNC_STAGES (2 or 3): depth of the input synchroniser.
//
// Optional feature macro UART_RX_MAJORITY_EN: when defined, every bit decision
// is the 2-of-3 majority of the samples at target-1, target and target+1, and
// is taken at target+1 (requires uart_divider >= 4). When undefined, a single
// sample is taken at target.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on rx_s
// START  | counting to mid start bit to confirm it
// DATA   | sampling 8 data bits, LSB first
// STOP   | sampling the stop bit, delivering the byte
// BREAK  | stop bit was low, waiting for the line to return high
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        uart_clk,
  input  logic        uart_rst_n,
  input  logic        uart_ser_rx,
  input  logic [15:0] uart_divider,
  uart_rx_if.master   rx_if
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

`ifdef UART_RX_MAJORITY_EN
  // Decision lands one cycle after target, so the data counter restarts at 1
  // to keep the following samples centred.
  localparam logic [15:0] CNT_RESTART = 16'd1;
`else
  localparam logic [15:0] CNT_RESTART = 16'd0;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        fe_q, fe_d;
  logic        ov_q, ov_d;

  logic [15:0] target;
  logic        decide;
  logic        bit_v;
  logic        accept;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] maj_q, maj_d;
  logic       pend_q, pend_d;
`endif

  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], uart_ser_rx};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      fe_q     <= 1'b0;
      ov_q     <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      maj_q    <= '0;
      pend_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      fe_q     <= fe_d;
      ov_q     <= ov_d;
`ifdef UART_RX_MAJORITY_EN
      maj_q    <= maj_d;
      pend_q   <= pend_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = valid_q;
    fe_d     = 1'b0;
    ov_d     = 1'b0;

    accept = valid_q && rx_if.uart_rx_ready;
    if (accept) valid_d = 1'b0;

    target = (state_q == START) ? (div_q >> 1) : div_q;

`ifdef UART_RX_MAJORITY_EN
    maj_d  = maj_q;
    pend_d = 1'b0;
    if (cnt_q == target - 16'd1) maj_d[0] = rx_s;
    if (cnt_q == target) begin
      maj_d[1] = rx_s;
      pend_d   = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    end
    decide = pend_q;
    bit_v  = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s) | (maj_q[1] & rx_s);
`else
    decide = (cnt_q == target);
    bit_v  = rx_s;
`endif

    // Free-running bit timer while a frame is in progress.
    if ((state_q == START) || (state_q == DATA) || (state_q == STOP)) begin
      cnt_d = (cnt_q == div_q) ? 16'd0 : cnt_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
          div_d   = uart_divider;
        end
      end
      START: begin
        if (decide) begin
          if (bit_v) begin
            state_d = IDLE;
          end else begin
            state_d  = DATA;
            cnt_d    = CNT_RESTART;
            bitcnt_d = '0;
          end
        end
      end
      DATA: begin
        if (decide) begin
          shift_d  = {bit_v, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (decide) begin
          if (bit_v) begin
            state_d = IDLE;
            // A slot is free if nothing is pending or the pending byte is
            // being accepted this very cycle.
            if (!valid_q || accept) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ov_d = 1'b1;
            end
          end else begin
            state_d = BREAK;
            fe_d    = 1'b1;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_if.uart_rx_data      = data_q;
  assign rx_if.uart_rx_valid     = valid_q;
  assign rx_if.uart_rx_frame_err = fe_q;
  assign rx_if.uart_rx_overrun   = ov_q;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  logic        uart_clk;
  logic        uart_rst_n;
  logic        uart_ser_rx;
  logic [15:0] uart_divider;

  uart_rx_if rx_if ();

  uart_rx #(.SYNC_STAGES(2)) dut (
    .uart_clk     (uart_clk),
    .uart_rst_n   (uart_rst_n),
    .uart_ser_rx  (uart_ser_rx),
    .uart_divider (uart_divider),
    .rx_if        (rx_if)
  );

  initial uart_clk = 1'b0;
  always #5 uart_clk = ~uart_clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] sb[$];
  int fe_cnt = 0;
  int ov_cnt = 0;
  int v_cyc  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on every accepted byte and tallies pulses.
  always @(negedge uart_clk) begin
    if (uart_rst_n) begin
      if (rx_if.uart_rx_valid) v_cyc++;
      if (rx_if.uart_rx_frame_err) fe_cnt++;
      if (rx_if.uart_rx_overrun) ov_cnt++;
      if (rx_if.uart_rx_valid && rx_if.uart_rx_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_byte", {24'd0, rx_if.uart_rx_data}, 32'hFFFF_FFFF);
        end else begin
          chk("rx_data", {24'd0, rx_if.uart_rx_data}, {24'd0, sb.pop_front()});
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge uart_clk);
    #2;
  endtask

  function automatic int per();
    return int'(uart_divider) + 1;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop);
    uart_ser_rx = 1'b0;
    wait_cyc(per());
    for (int i = 0; i < 8; i++) begin
      uart_ser_rx = b[i];
      wait_cyc(per());
    end
    uart_ser_rx = stop;
    wait_cyc(per());
  endtask

  task automatic clr_counts();
    fe_cnt = 0;
    ov_cnt = 0;
    v_cyc  = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, {31'd0, rx_if.uart_rx_valid}, 32'd0);
    chk({tag, "_data"}, {24'd0, rx_if.uart_rx_data}, 32'd0);
    chk({tag, "_fe"}, {31'd0, rx_if.uart_rx_frame_err}, 32'd0);
    chk({tag, "_ov"}, {31'd0, rx_if.uart_rx_overrun}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    uart_rst_n = 1'b0;
    uart_ser_rx = 1'b1;
    uart_divider = 16'd3;
    rx_if.uart_rx_ready = 1'b1;
    wait_cyc(3);
    chk_reset_state("reset");
    uart_rst_n = 1'b1;
    wait_cyc(4);

    // 0x55 at divider 3, ready held high.
    clr_counts();
    sb.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    wait_cyc(3 * per());
    chk("t1_sb_empty", sb.size(), 0);
    chk("t1_valid_cycles", v_cyc, 1);
    chk("t1_fe", fe_cnt, 0);
    chk("t1_ov", ov_cnt, 0);

    // Back-to-back 0xA3, 0x00 at divider 15.
    uart_divider = 16'd15;
    wait_cyc(2 * per());
    clr_counts();
    sb.push_back(8'hA3);
    sb.push_back(8'h00);
    send_frame(8'hA3, 1'b1);
    send_frame(8'h00, 1'b1);
    wait_cyc(3 * per());
    chk("t2_sb_empty", sb.size(), 0);
    chk("t2_valid_cycles", v_cyc, 2);
    chk("t2_fe", fe_cnt, 0);
    chk("t2_ov", ov_cnt, 0);

    // Overrun: 0x3C pending, 0xFF dropped.
    clr_counts();
    rx_if.uart_rx_ready = 1'b0;
    sb.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_cyc(2 * per());
    chk("t3_valid_held", {31'd0, rx_if.uart_rx_valid}, 32'd1);
    chk("t3_data_held", {24'd0, rx_if.uart_rx_data}, 32'h3C);
    chk("t3_ov_cycles", ov_cnt, 1);
    chk("t3_fe", fe_cnt, 0);
    rx_if.uart_rx_ready = 1'b1;
    wait_cyc(4);
    chk("t3_sb_empty", sb.size(), 0);
    chk("t3_valid_clear", {31'd0, rx_if.uart_rx_valid}, 32'd0);

    // Frame error followed by a long break, then 0x81.
    clr_counts();
    send_frame(8'hF0, 1'b0);
    wait_cyc(40 * per());
    chk("t4_fe_cycles", fe_cnt, 1);
    chk("t4_no_valid", v_cyc, 0);
    uart_ser_rx = 1'b1;
    wait_cyc(2 * per());
    sb.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    wait_cyc(3 * per());
    chk("t4_sb_empty", sb.size(), 0);
    chk("t4_valid_cycles", v_cyc, 1);
    chk("t4_fe_total", fe_cnt, 1);

    // 3-cycle glitch, then 0x7E.
    clr_counts();
    uart_ser_rx = 1'b0;
    wait_cyc(3);
    uart_ser_rx = 1'b1;
    wait_cyc(2 * per());
    chk("t5_glitch_valid", v_cyc, 0);
    chk("t5_glitch_fe", fe_cnt, 0);
    sb.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    wait_cyc(3 * per());
    chk("t5_sb_empty", sb.size(), 0);
    chk("t5_valid_cycles", v_cyc, 1);

    // Reset in bit 4 with a byte pending; both are lost, then 0x12.
    rx_if.uart_rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    wait_cyc(per());
    uart_ser_rx = 1'b0;
    wait_cyc(per());
    for (int i = 0; i < 4; i++) begin
      uart_ser_rx = (i % 2 == 1);
      wait_cyc(per());
    end
    uart_ser_rx = 1'b0;
    wait_cyc(per() / 2);
    uart_rst_n = 1'b0;
    uart_ser_rx = 1'b1;
    wait_cyc(3);
    chk_reset_state("midreset");
    uart_rst_n = 1'b1;
    wait_cyc(2 * per());
    clr_counts();
    rx_if.uart_rx_ready = 1'b1;
    sb.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    wait_cyc(3 * per());
    chk("t6_sb_empty", sb.size(), 0);
    chk("t6_valid_cycles", v_cyc, 1);
    chk("t6_fe", fe_cnt, 0);
    chk("t6_ov", ov_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that deserialises an 8N1 asynchronous line into bytes. It is the receive-side counterpart of the UART transmitter and uses the same divider convention: one bit period is uart_divider+1 uart_clk cycles.
- Sits between the external RX pin (or a transmitter's serial output in loopback) and a byte-wide valid/ready consumer such as a FIFO or bus register.

Parameters:
SYNC_STAGES, 2, number of flops in the input synchroniser chain; allowed values 2 or 3.

Ports:
uart_clk  input  1  system clock
uart_rst_n  input  1  reset; asynchronous, active-low
uart_ser_rx  input  1  serial line; idle high; asynchronous to uart_clk
uart_divider  input  16  bit period minus one, in uart_clk cycles; legal range 3..65535
uart_rx_data  output  8  received byte; valid while uart_rx_valid=1
uart_rx_valid  output  1  byte available
uart_rx_ready  input  1  consumer accepts the byte
uart_rx_frame_err  output  1  one-cycle pulse: stop bit sampled as 0
uart_rx_overrun  output  1  one-cycle pulse: a byte completed while the previous one was still unaccepted

Behaviour:
- Reset (async assert, sync release):
  - all synchroniser flops = 1
  - state = IDLE
  - uart_rx_data = 0
  - uart_rx_valid = 0
  - uart_rx_frame_err = 0
  - uart_rx_overrun = 0
  - counters = 0
- Synchroniser: uart_ser_rx passes through SYNC_STAGES flops. All decisions use the last flop (rx_s).
- Divider latch: uart_divider is captured into div_l on start detection. Changing the input mid-frame has no effect on the current frame.
- Bit counter cnt: counts 0..div_l, then wraps to 0. One wrap = one bit period.
- States:
  - IDLE: rx_s=0 -> START, cnt=0, div_l=uart_divider.
  - START: when cnt == div_l>>1 (mid start bit), sample rx_s.
    - 1 -> glitch; go to IDLE with no output.
    - 0 -> cnt=0, bitcnt=0, go to DATA.
  - DATA: when cnt==div_l, sample rx_s into the shift register, LSB first (shift right, new bit into bit 7), and increment bitcnt. After the 8th sample -> STOP.
  - STOP: when cnt==div_l, sample rx_s.
    - 1 -> deliver the byte, go to IDLE.
    - 0 -> pulse uart_rx_frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE. Prevents a held-low line from being read as repeated 0x00 frames.
- Sampling points: the start bit is sampled at its middle. Every later sample is one full period after the previous one, so it also lands at mid-bit.
- Delivery, output handshake:
  - On the stop-sample edge, uart_rx_data and uart_rx_valid=1 are registered, so they are visible the next cycle.
  - Latency from line start-edge to valid ≈ 9.5 bit periods + SYNC_STAGES + 1 cycles.
  - uart_rx_valid holds, with uart_rx_data stable, until a cycle where uart_rx_valid && uart_rx_ready. It clears on the following edge.
- Overrun: a byte completes while valid=1 and ready=0.
  - The new byte is dropped; the old data and valid are retained.
  - uart_rx_overrun pulses for 1 cycle.
- Simultaneous delivery and acceptance: delivery in the same cycle as valid&&ready loads the new byte, valid stays 1, and there is no overrun.
- Frame error with a pending byte: only frame_err pulses. Valid and data are untouched.
- Back-to-back frames: IDLE re-arms immediately after the stop sample, so a start bit beginning half a period later is caught.
- Reset mid-frame: the partial byte is lost and the pending byte is lost. No pulse is generated.
- uart_divider < 3 is illegal; behaviour is unspecified.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each start, data and stop sample is the 2-of-3 majority of rx_s at cnt = target-1, target and target+1, where target is div_l>>1 for the start bit and div_l otherwise. The decision is made at target+1, so all state transitions slip by 1 cycle. Requires uart_divider >= 4.
- Undefined: a single sample at target, exactly as described in Behaviour.

Test Plan:
- divider=3, send 0x55 with an ideal 4-cycle bit -> valid rises once, data=0x55, no error pulses; with ready=1 held, valid lasts 1 cycle.
- divider=15, send 0xA3 then 0x00 back-to-back (stop bit followed immediately by start), ready held 1 -> two deliveries, 0xA3 then 0x00, no errors.
- divider=15, send 0x3C with ready=0, then send 0xFF -> valid stays 1 with data=0x3C; overrun pulses exactly 1 cycle at the second stop sample; after ready, data=0x3C is consumed and 0xFF never appears.
- divider=15, frame with stop bit=0 followed by line held low for 40 bit periods -> one frame_err pulse, no valid, no further frames; after line high, sending 0x81 -> data=0x81.
- divider=15, 3-cycle low glitch on an idle line -> no valid, no frame_err, FSM back to IDLE; then 0x7E is received correctly.
- Assert uart_rst_n low during bit 4 of a frame, release, then send 0x12 -> no output from the aborted frame; data=0x12 delivered.
